boot_image_loader: RTL and testbench

BOOT_IMAGE_LOADER -- requirements
Module: boot_image_loader

---
 rtl/boot_pkg.sv | 16 +
 rtl/line_packer.sv | 39 +++
 rtl/boot_image_loader.sv | 153 +++++++++++++++
 tb/tb_boot_image_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot image loader: FSM state encoding and
// default line/block geometry.
package boot_pkg;

    localparam int DEF_LINE_BYTES  = 64;
    localparam int DEF_BLOCK_BYTES = 512;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/line_packer.sv
// Packs an accepted byte stream into one memory line; the byte index
// picks the slot, mirrored when swap is set.
module line_packer
    import boot_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    swap,
    input  logic [7:0]              byte_in,
    output logic [8*LINE_BYTES-1:0] line,
    output logic                    last
);

    localparam int IW = $clog2(LINE_BYTES);

    logic [IW-1:0] idx;
    logic [IW-1:0] slot;

    assign last = &idx;
    // LINE_BYTES is a power of two, so ~idx == LINE_BYTES-1-idx.
    assign slot = swap ? ~idx : idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx  <= '0;
            line <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (load) begin
            line[{slot, 3'b000} +: 8] <= byte_in;
            idx                       <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/boot_image_loader.sv
// Loads a byte stream into memory lines for up to NCHAN channels in turn,
// each channel covering block_count blocks starting at block_addr.
module boot_image_loader
    import boot_pkg::*;
#(
    parameter int NCHAN       = 2,
    parameter int LINE_BYTES  = DEF_LINE_BYTES,
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int ADDR_W      = 32
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            start,
    input  logic                                            abort,
    input  logic                                            swap,
    input  logic [NCHAN*32-1:0]                             block_addr,
    input  logic [NCHAN*32-1:0]                             block_count,
    input  logic                                            in_valid,
    input  logic [7:0]                                      in_data,
    output logic                                            in_ready,
    output logic                                            mem_valid,
    output logic [ADDR_W-1:0]                               mem_addr,
    output logic [8*LINE_BYTES-1:0]                         mem_data,
    input  logic                                            mem_ready,
    output logic                                            busy,
    output logic                                            done,
    output logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0]    chan
);

    localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int IXW = $clog2(NCHAN + 1);
    localparam int SH  = $clog2(BLOCK_BYTES / LINE_BYTES);
    localparam int AEW = ADDR_W + $clog2(BLOCK_BYTES);
    localparam int LCW = 32 + SH;

    state_t               state, state_next;
    logic [IXW-1:0]       idx;
    logic [NCHAN*32-1:0]  addr_lat, count_lat;
    logic                 swap_lat;
    logic [LCW-1:0]       line_cnt;
    logic [31:0]          cur_addr, cur_count;
    logic                 more;
    logic                 last;
    logic                 accept;

    assign accept = in_valid & in_ready;
    assign chan   = idx[CHW-1:0];

    // idx may run one past the last channel, which marks "no channel left".
    always_comb begin
        cur_addr  = '0;
        cur_count = '0;
        more      = 1'b0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            if (idx == IXW'(i)) begin
                cur_addr  = addr_lat[i*32 +: 32];
                cur_count = count_lat[i*32 +: 32];
                more      = 1'b1;
            end
        end
    end

    line_packer #(
        .LINE_BYTES (LINE_BYTES)
    ) u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (abort || (state == IDLE)),
        .load    (accept && !abort),
        .swap    (swap_lat),
        .byte_in (in_data),
        .line    (mem_data),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = NEXT;
            end
            NEXT: begin
                if (!more)                state_next = DONE;
                else if (cur_count != '0) state_next = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && last) state_next = WRITE;
            end
            WRITE: begin
                mem_valid = 1'b1;
                if (mem_ready) state_next = (line_cnt == LCW'(1)) ? NEXT : FILL;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx       <= '0;
            addr_lat  <= '0;
            count_lat <= '0;
            swap_lat  <= 1'b0;
            line_cnt  <= '0;
            mem_addr  <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_lat  <= block_addr;
                        count_lat <= block_count;
                        swap_lat  <= swap;
                        idx       <= '0;
                    end
                end
                NEXT: begin
                    if (more) begin
                        if (cur_count != '0) begin
                            line_cnt <= LCW'(cur_count) << SH;
                            mem_addr <= ADDR_W'(AEW'(cur_addr) << SH);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_addr <= mem_addr + 1'b1;
                        line_cnt <= line_cnt - 1'b1;
                        if (line_cnt == LCW'(1)) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_image_loader.sv
// Randomized bench for boot_image_loader: a queue-based reference model of
// the expected line writes is checked against the DUT every cycle.
module tb_boot_image_loader;

    localparam int LB  = 8;
    localparam int BB  = 64;
    localparam int LPB = BB / LB;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, swap;
    logic [63:0] block_addr, block_count;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic        mem_ready = 1'b0;
    logic        busy, done;
    logic [0:0]  chan;

    logic        start2, abort2, swap2, in_valid2, mem_ready2;
    logic [63:0] block_addr2, block_count2;
    logic [7:0]  in_data2;
    logic        in_ready2, mem_valid2, busy2, done2;
    logic [7:0]  mem_addr2;
    logic [63:0] mem_data2;
    logic [0:0]  chan2;

    always #5 clk = ~clk;

    boot_image_loader #(
        .NCHAN (2), .LINE_BYTES (LB), .BLOCK_BYTES (BB), .ADDR_W (32)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start), .abort (abort), .swap (swap),
        .block_addr (block_addr), .block_count (block_count),
        .in_valid (in_valid), .in_data (in_data), .in_ready (in_ready),
        .mem_valid (mem_valid), .mem_addr (mem_addr), .mem_data (mem_data),
        .mem_ready (mem_ready), .busy (busy), .done (done), .chan (chan)
    );

    // Narrow address instance: two lines per block so the line address can hit 0xFE.
    boot_image_loader #(
        .NCHAN (2), .LINE_BYTES (8), .BLOCK_BYTES (16), .ADDR_W (8)
    ) dut2 (
        .clk (clk), .reset_n (reset_n), .start (start2), .abort (abort2), .swap (swap2),
        .block_addr (block_addr2), .block_count (block_count2),
        .in_valid (in_valid2), .in_data (in_data2), .in_ready (in_ready2),
        .mem_valid (mem_valid2), .mem_addr (mem_addr2), .mem_data (mem_data2),
        .mem_ready (mem_ready2), .busy (busy2), .done (done2), .chan (chan2)
    );

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic        ch;
    } wr_t;

    wr_t         expq[$];
    logic [7:0]  src [1024];
    logic [31:0] cfg_addr [2];
    logic [31:0] cfg_cnt [2];
    logic        cfg_swap;
    int          ptr = 0, tests = 0, fails = 0;
    int          done_seen = 0, pending = 0, writes_this_load = 0;
    int          stall_line = -1, stall_left = 0, in_prob = 100, out_prob = 100;
    logic [31:0] first_addr, last_addr;
    logic [63:0] first_data;
    logic        first_ch;
    logic        prev_stall = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_addr;
    logic [63:0] prev_data;
    logic [7:0]  wa2[$];
    int          done2_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Expected writes: channel after channel, line k of a channel lands at
    // addr*BB/LB + k (mod 2^32) and carries stream bytes n*LB .. n*LB+LB-1.
    task automatic model_load();
        int n = 0;
        expq.delete();
        ptr              = 0;
        pending          = 1;
        writes_this_load = 0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < int'(cfg_cnt[c]) * LPB; k++) begin
                wr_t         e;
                logic [63:0] t;
                t      = 64'(cfg_addr[c]) * LPB + 64'(k);
                e.addr = t[31:0];
                e.ch   = c[0];
                e.data = '0;
                for (int j = 0; j < LB; j++) begin
                    if (cfg_swap) e.data[8*(LB-1-j) +: 8] = src[n*LB + j];
                    else          e.data[8*j +: 8]        = src[n*LB + j];
                end
                expq.push_back(e);
                n++;
            end
        end
        block_addr  = {cfg_addr[1], cfg_addr[0]};
        block_count = {cfg_cnt[1], cfg_cnt[0]};
        swap        = cfg_swap;
    endtask

    task automatic start_load();
        model_load();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic finish_load(input string tag, input int lines);
        int d0 = done_seen;
        int n  = 0;
        while (done_seen == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == d0) fail_now({tag, "_done_timeout"});
        @(negedge clk);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_writes"}, writes_this_load, lines);
    endtask

    task automatic wait_bytes(input string tag, input int count);
        int n = 0;
        while (ptr < count && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ptr < count) fail_now(tag);
    endtask

    // Drives source/sink each cycle, then checks the outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            in_valid = ($urandom_range(99) < in_prob);
            in_data  = src[ptr % 1024];
            if (in_valid && in_ready) ptr++;
            mem_ready = ($urandom_range(99) < out_prob);
            if (mem_valid && writes_this_load == stall_line && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end
            if (reset_n) begin
                if (prev_stall) begin
                    chk("stall_valid", mem_valid, 1);
                    chk("stall_addr", mem_addr, prev_addr);
                    chk("stall_data", mem_data, prev_data);
                end
                if (mem_valid) chk("in_ready_in_write", in_ready, 0);
                if (mem_valid || in_ready) chk("busy_active", busy, 1);
                if (done) begin
                    chk("done_width", prev_done, 0);
                    chk("done_expected", pending, 1);
                    chk("queue_drained", expq.size(), 0);
                    pending = 0;
                    done_seen++;
                end
                if (mem_valid && mem_ready) begin
                    if (expq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr %h, no write expected", mem_addr);
                    end else begin
                        wr_t e;
                        e = expq.pop_front();
                        chk("write_addr", mem_addr, e.addr);
                        chk("write_data", mem_data, e.data);
                        chk("write_chan", chan, e.ch);
                        if (writes_this_load == 0) begin
                            first_addr = mem_addr;
                            first_data = mem_data;
                            first_ch   = chan;
                        end
                        last_addr = mem_addr;
                        writes_this_load++;
                    end
                end
                if (mem_valid2 && mem_ready2) wa2.push_back(mem_addr2);
                if (done2) done2_seen++;
            end
            prev_stall = reset_n && mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            prev_done  = done;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp2 [4];
        int         n;
        exp2 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        reset_n = 1'b0; start = 1'b1; abort = 1'b0; swap = 1'b0;
        block_addr = '0; block_count = '0;
        start2 = 1'b0; abort2 = 1'b0; swap2 = 1'b0; in_valid2 = 1'b1; in_data2 = 8'h00;
        mem_ready2 = 1'b1; block_addr2 = {32'd0, 32'h17F}; block_count2 = {32'd0, 32'd2};

        // Reset wins over a held start.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_chan", chan, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 1024; i++) src[i] = 8'(i);
        cfg_addr = '{32'd2, 32'd0}; cfg_cnt = '{32'd1, 32'd0}; cfg_swap = 1'b0;
        start_load();
        finish_load("basic", 8);
        chk("basic_first_addr", first_addr, 32'd16);
        chk("basic_first_data", first_data, 64'h0706050403020100);
        chk("basic_last_addr", last_addr, 32'd23);
        chk("basic_first_chan", first_ch, 0);
        chk("basic_done_count", done_seen, 1);

        cfg_swap = 1'b1;
        start_load();
        finish_load("swap", 8);
        chk("swap_first_data", first_data, 64'h0001020304050607);

        cfg_addr = '{32'd7, 32'd0}; cfg_cnt = '{32'd0, 32'd1}; cfg_swap = 1'b0;
        start_load();
        finish_load("skip", 8);
        chk("skip_first_addr", first_addr, 32'd0);
        chk("skip_first_chan", first_ch, 1);

        cfg_addr = '{32'd2, 32'd0}; cfg_cnt = '{32'd1, 32'd0};
        stall_line = 1; stall_left = 5;
        start_load();
        finish_load("stall", 8);
        chk("stall_cycles_used", stall_left, 0);
        stall_line = -1;

        for (int i = 0; i < 1024; i++) src[i] = 8'(i + 'h40);
        cfg_addr = '{32'd5, 32'd0}; cfg_cnt = '{32'd1, 32'd0};
        start_load();
        wait_bytes("abort_bytes_timeout", LB + 3);
        n = done_seen;
        @(negedge clk);
        abort   = 1'b1;
        expq.delete();
        pending = 0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mem_valid", mem_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_seen, n);
        start_load();
        finish_load("reload", 8);
        chk("reload_first_addr", first_addr, 32'd40);
        chk("reload_first_data", first_data, 64'h4746454443424140);

        cfg_addr = '{32'd9, 32'd3}; cfg_cnt = '{32'd2, 32'd1};
        in_prob = 70; out_prob = 70;
        start_load();
        wait_bytes("rst_mid_bytes_timeout", 20);
        @(negedge clk);
        reset_n = 1'b0;
        expq.delete();
        pending = 0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mem_valid", mem_valid, 0);
        chk("rst_mid_in_ready", in_ready, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_mid_quiet_busy", busy, 0);
        chk("rst_mid_quiet_valid", mem_valid, 0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 1024; i++) src[i] = 8'($urandom);
            for (int c = 0; c < 2; c++) begin
                cfg_cnt[c]  = $urandom_range(2);
                cfg_addr[c] = $urandom;
            end
            if (r == 0) begin
                cfg_addr[0] = 32'hFFFF_FFFF;
                cfg_cnt[0]  = 32'd2;
            end
            cfg_swap = 1'($urandom_range(1));
            in_prob  = $urandom_range(100, 40);
            out_prob = $urandom_range(100, 40);
            start_load();
            finish_load("rand", int'(cfg_cnt[0] + cfg_cnt[1]) * LPB);
        end

        wa2.delete();
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        n = 0;
        while (done2_seen == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done2_seen == 0) fail_now("wrap_done_timeout");
        chk("wrap_write_count", wa2.size(), 4);
        for (int i = 0; i < 4 && i < wa2.size(); i++) chk("wrap_addr", wa2[i], exp2[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
